// File: rtl/noc_pkg.sv
// Shared definitions for the NoC packet transmitter: flit width,
// header field layout and FSM state encoding.
`timescale 1ns/1ps
package noc_pkg;

  // Link flit width
  localparam int FLIT_W = 64;

  // Header field layout: [63:60] dest, [59:56] src, [55:50] len, [49:0] zero
  localparam int HDR_DEST_LSB = 60;
  localparam int HDR_DEST_W   = 4;
  localparam int HDR_SRC_LSB  = 56;
  localparam int HDR_SRC_W    = 4;
  localparam int HDR_LEN_LSB  = 50;
  localparam int HDR_LEN_W    = 6;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HDR     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

endpackage

// File: rtl/noc_pkt_tx.sv
// NoC packet transmitter: drains an upstream FIFO into header + payload
// packets of at most MAX_LEN flits on a valid/ready link.
`timescale 1ns/1ps
module noc_pkt_tx
  import noc_pkg::*;
#(
  parameter int         MAX_LEN = 8,
  parameter logic [3:0] SRC_ID  = 4'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [4:0]        fifo_ocup,
  input  logic [FLIT_W-1:0] fifo_data,
  output logic              fifo_read_en,
  input  logic [3:0]        dest_id,
  output logic              link_valid,
  input  logic              link_ready,
  output logic [FLIT_W-1:0] link_data,
  output logic              link_sof,
  output logic              link_eof,
  output logic              busy,
  output logic              underrun,
  output logic [15:0]       pkt_count
);

  localparam logic [HDR_LEN_W-1:0] MAX_LEN_C = HDR_LEN_W'(MAX_LEN);

  logic [1:0]           state_q, state_d;
  logic [HDR_LEN_W-1:0] len_q, len_d;
  logic [HDR_LEN_W-1:0] rem_q, rem_d;
  logic [FLIT_W-1:0]    hdr_q, hdr_d;
  logic                 underrun_q, underrun_d;
  logic [15:0]          pkt_count_q, pkt_count_d;

  logic [HDR_LEN_W-1:0] eff_ocup_s;
  logic [HDR_LEN_W-1:0] new_len_s;
  logic [FLIT_W-1:0]    new_hdr_s;
  logic                 xfer_s;

  // Packet length for a new packet: occupancy (0 with data means 32) capped at MAX_LEN
  always_comb begin
    if (fifo_ocup == 5'd0) begin
      eff_ocup_s = 6'd32;
    end else begin
      eff_ocup_s = {1'b0, fifo_ocup};
    end
    if (eff_ocup_s < MAX_LEN_C) begin
      new_len_s = eff_ocup_s;
    end else begin
      new_len_s = MAX_LEN_C;
    end
  end

  // Header word assembled from the fields captured at packet start
  always_comb begin
    new_hdr_s = {FLIT_W{1'b0}};
    new_hdr_s[HDR_DEST_LSB +: HDR_DEST_W] = dest_id;
    new_hdr_s[HDR_SRC_LSB  +: HDR_SRC_W]  = SRC_ID;
    new_hdr_s[HDR_LEN_LSB  +: HDR_LEN_W]  = new_len_s;
  end

  // Link-side outputs: header from register, payload straight from the FIFO head
  always_comb begin
    link_valid   = 1'b0;
    link_sof     = 1'b0;
    link_eof     = 1'b0;
    link_data    = {FLIT_W{1'b0}};
    fifo_read_en = 1'b0;
    case (state_q)
      ST_HDR: begin
        link_valid = 1'b1;
        link_sof   = 1'b1;
        link_data  = hdr_q;
      end
      ST_PAYLOAD: begin
        link_valid   = ~fifo_empty;
        link_eof     = (rem_q == 6'd1);
        link_data    = fifo_data;
        fifo_read_en = ~fifo_empty & link_ready;
      end
      default: begin
        link_valid = 1'b0;
      end
    endcase
  end

  assign xfer_s    = link_valid & link_ready;
  assign busy      = (state_q != ST_IDLE);
  assign underrun  = underrun_q;
  assign pkt_count = pkt_count_q;

  // Next-state logic for the packet FSM, counters and sticky error
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rem_d       = rem_q;
    hdr_d       = hdr_q;
    underrun_d  = underrun_q;
    pkt_count_d = pkt_count_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          len_d   = new_len_s;
          hdr_d   = new_hdr_s;
          state_d = ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (xfer_s) begin
          rem_d   = len_q;
          state_d = ST_PAYLOAD;
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_PAYLOAD: begin
        // Running dry mid-packet is an upstream fault; wait for data
        if (fifo_empty) begin
          underrun_d = 1'b1;
        end else begin
          underrun_d = underrun_q;
        end
        if (xfer_s) begin
          if (rem_q == 6'd1) begin
            rem_d       = 6'd0;
            pkt_count_d = pkt_count_q + 16'd1;
            state_d     = ST_IDLE;
          end else begin
            rem_d   = rem_q - 6'd1;
            state_d = ST_PAYLOAD;
          end
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= 6'd0;
      rem_q       <= 6'd0;
      hdr_q       <= {FLIT_W{1'b0}};
      underrun_q  <= 1'b0;
      pkt_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      hdr_q       <= hdr_d;
      underrun_q  <= underrun_d;
      pkt_count_q <= pkt_count_d;
    end
  end

endmodule

// File: tb/tb_noc_pkt_tx.sv
// Self-checking bench for noc_pkt_tx: a queue-based FIFO model feeds the DUT and
// the flit stream on the link is compared against packets chunked from the FIFO contents.
`timescale 1ns/1ps
module tb_noc_pkt_tx;

  localparam logic [3:0] SRC8  = 4'hA;
  localparam logic [3:0] SRC32 = 4'h5;

  typedef struct packed {
    logic [63:0] data;
    logic        sof;
    logic        eof;
  } flit_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel32 = 1'b0;
  logic        hide = 1'b0;
  logic        link_ready = 1'b1;
  logic [3:0]  dest_id = 4'h0;
  logic        f_empty = 1'b1;
  logic [4:0]  f_ocup = 5'd0;
  logic [63:0] f_data = 64'd0;
  logic        empty8, empty32;

  logic        re8, v8, sof8, eof8, busy8, un8;
  logic [63:0] d8;
  logic [15:0] cnt8;
  logic        re32, v32, sof32, eof32, busy32, un32;
  logic [63:0] d32;
  logic [15:0] cnt32;

  logic        re, v, sof, eof, busy, un;
  logic [63:0] d;
  logic [15:0] cnt;

  always #5 clk = ~clk;

  // The unselected DUT sees an empty FIFO and stays idle
  assign empty8  = sel32 ? 1'b1 : f_empty;
  assign empty32 = sel32 ? f_empty : 1'b1;

  assign re   = sel32 ? re32   : re8;
  assign v    = sel32 ? v32    : v8;
  assign sof  = sel32 ? sof32  : sof8;
  assign eof  = sel32 ? eof32  : eof8;
  assign busy = sel32 ? busy32 : busy8;
  assign un   = sel32 ? un32   : un8;
  assign d    = sel32 ? d32    : d8;
  assign cnt  = sel32 ? cnt32  : cnt8;

  noc_pkt_tx #(.MAX_LEN(8), .SRC_ID(SRC8)) dut8 (
    .clk(clk), .reset(reset), .fifo_empty(empty8), .fifo_ocup(f_ocup),
    .fifo_data(f_data), .fifo_read_en(re8), .dest_id(dest_id),
    .link_valid(v8), .link_ready(link_ready), .link_data(d8),
    .link_sof(sof8), .link_eof(eof8), .busy(busy8), .underrun(un8),
    .pkt_count(cnt8)
  );

  noc_pkt_tx #(.MAX_LEN(32), .SRC_ID(SRC32)) dut32 (
    .clk(clk), .reset(reset), .fifo_empty(empty32), .fifo_ocup(f_ocup),
    .fifo_data(f_data), .fifo_read_en(re32), .dest_id(dest_id),
    .link_valid(v32), .link_ready(link_ready), .link_data(d32),
    .link_sof(sof32), .link_eof(eof32), .busy(busy32), .underrun(un32),
    .pkt_count(cnt32)
  );

  logic [63:0] q[$];
  flit_t       exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          ready_mode = 0;
  int          payload_seen = 0;
  int          pops = 0;
  int          exp_pkts = 0;
  int          last_ticks = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_d = 64'd0;
  logic        prev_sof = 1'b0;
  logic        prev_eof = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic refresh();
    f_empty = (q.size() == 0) || hide;
    f_ocup  = 5'(q.size());
    f_data  = (q.size() != 0) ? q[0] : 64'd0;
  endtask

  task automatic push_words(input int n);
    for (int k = 0; k < n; k++) q.push_back({$urandom, $urandom});
  endtask

  function automatic logic [63:0] hdr_word(input logic [3:0] dst, input logic [3:0] src, input int n);
    logic [5:0] l;
    l = 6'(n);
    return {dst, src, l, 50'd0};
  endfunction

  // Chunk FIFO words from index 'first' into packets of at most maxlen
  task automatic build(input int first, input int maxlen, input logic [3:0] src);
    int i;
    int n;
    flit_t f;
    i = first;
    while (i < q.size()) begin
      n = q.size() - i;
      if (n > maxlen) n = maxlen;
      f.data = hdr_word(dest_id, src, n);
      f.sof = 1'b1;
      f.eof = 1'b0;
      exp_q.push_back(f);
      for (int k = 0; k < n; k++) begin
        f.data = q[i + k];
        f.sof = 1'b0;
        f.eof = (k == n - 1);
        exp_q.push_back(f);
      end
      i += n;
      exp_pkts++;
    end
  endtask

  task automatic tick();
    flit_t want;
    logic pop;
    logic [63:0] dropped;
    @(negedge clk);
    chk("read_en_rule", 64'(re), 64'(v & link_ready & ~sof));
    if (v) chk("busy_when_valid", 64'(busy), 64'd1);
    if (prev_stall) begin
      chk("stall_valid", 64'(v), 64'd1);
      chk("stall_data", d, prev_d);
      chk("stall_sof", 64'(sof), 64'(prev_sof));
      chk("stall_eof", 64'(eof), 64'(prev_eof));
    end
    if (v && link_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_flit", 64'(exp_q.size()), 64'd1);
      end else begin
        want = exp_q.pop_front();
        chk("flit_data", d, want.data);
        chk("flit_sof", 64'(sof), 64'(want.sof));
        chk("flit_eof", 64'(eof), 64'(want.eof));
      end
      if (!sof) payload_seen++;
    end
    prev_stall = v && !link_ready;
    prev_d = d;
    prev_sof = sof;
    prev_eof = eof;
    pop = re;
    @(posedge clk);
    #1;
    if (pop) begin
      if (q.size() > 0) dropped = q.pop_front();
      pops++;
    end
    case (ready_mode)
      0: link_ready = 1'b1;
      1: link_ready = ~link_ready;
      default: link_ready = 1'($urandom_range(0, 1));
    endcase
    refresh();
  endtask

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
    last_ticks = n;
  endtask

  task automatic idle_check(input string tag);
    tick();
    tick();
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_valid"}, 64'(v), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    refresh();
    #2;
    // Outputs while reset is held
    chk("rst_valid", 64'(v), 64'd0);
    chk("rst_sof", 64'(sof), 64'd0);
    chk("rst_eof", 64'(eof), 64'd0);
    chk("rst_read_en", 64'(re), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_underrun", 64'(un), 64'd0);
    chk("rst_pkt_count", 64'(cnt), 64'd0);
    chk("rst_data", d, 64'd0);
    chk("rst_busy32", 64'(busy32), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 3 words, ready always high: len 3, minimum latency 1+1+3
    ready_mode = 0;
    dest_id = 4'($urandom);
    pops = 0;
    push_words(3);
    build(0, 8, SRC8);
    refresh();
    drain("s1_drain", 20);
    chk("s1_latency", 64'(last_ticks), 64'd5);
    chk("s1_pkt_count", 64'(cnt), 64'(exp_pkts));
    chk("s1_pops", 64'(pops), 64'd3);
    idle_check("s1_idle");

    // Words arriving after the packet starts do not change its length
    dest_id = 4'($urandom);
    push_words(3);
    build(0, 8, SRC8);
    refresh();
    tick();
    push_words(2);
    build(3, 8, SRC8);
    refresh();
    drain("s2_drain", 40);
    chk("s2_pkt_count", 64'(cnt), 64'(exp_pkts));
    idle_check("s2_idle");

    // 20 words with MAX_LEN 8 and random ready: packets 8, 8, 4
    ready_mode = 2;
    dest_id = 4'($urandom);
    push_words(20);
    build(0, 8, SRC8);
    refresh();
    drain("s3_drain", 300);
    chk("s3_pkt_count", 64'(cnt), 64'(exp_pkts));
    idle_check("s3_idle");

    // Ready toggling every cycle: no duplication or loss, stable while stalled
    ready_mode = 1;
    dest_id = 4'($urandom);
    push_words(6);
    build(0, 8, SRC8);
    refresh();
    drain("s4_drain", 100);
    chk("s4_pkt_count", 64'(cnt), 64'(exp_pkts));
    idle_check("s4_idle");

    // FIFO runs dry mid-payload: sticky underrun, valid low, then resumes
    ready_mode = 0;
    dest_id = 4'($urandom);
    push_words(5);
    build(0, 8, SRC8);
    refresh();
    payload_seen = 0;
    for (int n = 0; n < 30 && payload_seen < 2; n++) tick();
    chk("s5_reach", 64'(payload_seen), 64'd2);
    chk("s5_no_underrun_yet", 64'(un), 64'd0);
    hide = 1'b1;
    refresh();
    tick();
    tick();
    chk("s5_underrun", 64'(un), 64'd1);
    chk("s5_valid_low", 64'(v), 64'd0);
    chk("s5_busy", 64'(busy), 64'd1);
    chk("s5_read_en", 64'(re), 64'd0);
    hide = 1'b0;
    refresh();
    drain("s5_drain", 40);
    chk("s5_pkt_count", 64'(cnt), 64'(exp_pkts));
    idle_check("s5_idle");
    chk("s5_sticky", 64'(un), 64'd1);

    // Reset during the second payload flit abandons the packet
    dest_id = 4'($urandom);
    push_words(5);
    build(0, 8, SRC8);
    refresh();
    payload_seen = 0;
    for (int n = 0; n < 30 && payload_seen < 1; n++) tick();
    chk("s6_reach", 64'(payload_seen), 64'd1);
    reset = 1'b1;
    #1;
    chk("s6_valid", 64'(v), 64'd0);
    chk("s6_sof", 64'(sof), 64'd0);
    chk("s6_eof", 64'(eof), 64'd0);
    chk("s6_read_en", 64'(re), 64'd0);
    chk("s6_busy", 64'(busy), 64'd0);
    chk("s6_underrun", 64'(un), 64'd0);
    chk("s6_pkt_count", 64'(cnt), 64'd0);
    chk("s6_data", d, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    prev_stall = 1'b0;
    exp_pkts = 0;
    chk("s6_words_left", 64'(q.size()), 64'd4);
    build(0, 8, SRC8);
    refresh();
    drain("s6_drain", 40);
    chk("s6_pkt_count_after", 64'(cnt), 64'(exp_pkts));
    idle_check("s6_idle");

    // Full FIFO (occupancy 0, not empty) with MAX_LEN 32: one packet of 32
    sel32 = 1'b1;
    exp_pkts = 0;
    pops = 0;
    dest_id = 4'($urandom);
    push_words(32);
    build(0, 32, SRC32);
    refresh();
    chk("s7_ocup_wrap", 64'(f_ocup), 64'd0);
    drain("s7_drain", 100);
    chk("s7_pops", 64'(pops), 64'd32);
    chk("s7_pkt_count", 64'(cnt), 64'(exp_pkts));
    idle_check("s7_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/noc_pkt_tx.md
NOC_PKT_TX -- requirements
Module: noc_pkt_tx

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 8, giving the maximum payload flits per packet (legal 1..32).
REQ-002 The block SHALL have parameter SRC_ID, default 4'h0, giving the source node ID placed in every header.
REQ-003 The block SHALL have port clk, input, 1, the clock.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port fifo_empty, input, 1, the upstream FIFO empty flag.
REQ-006 The block SHALL have port fifo_ocup, input, 5, the upstream FIFO occupancy; a value of 0 with fifo_empty=0 means 32.
REQ-007 The block SHALL have port fifo_data, input, 64, the combinational FIFO head word.
REQ-008 The block SHALL have port fifo_read_en, output, 1, the pop strobe to the FIFO.
REQ-009 The block SHALL have port dest_id, input, 4, the destination node, sampled at packet start.
REQ-010 The block SHALL have port link_valid, output, 1, indicating a flit is present.
REQ-011 The block SHALL have port link_ready, input, 1, the link accept signal.
REQ-012 The block SHALL have port link_data, output, 64, the flit payload.
REQ-013 The block SHALL have port link_sof, output, 1, marking the header flit.
REQ-014 The block SHALL have port link_eof, output, 1, marking the last payload flit.
REQ-015 The block SHALL have port busy, output, 1, high whenever state != IDLE.
REQ-016 The block SHALL have port underrun, output, 1, a sticky error flag.
REQ-017 The block SHALL have port pkt_count, output, 16, the count of completed packets (wraps).

Function
REQ-018 The FSM SHALL have states IDLE, HDR and PAYLOAD.
REQ-019 In IDLE with fifo_empty=0, the block SHALL latch len = min(effective ocup, MAX_LEN) and dest_id, then enter HDR on the next edge.
REQ-020 In HDR, the block SHALL drive link_valid=1, link_sof=1 and a registered header: [63:60] dest, [59:56] SRC_ID, [55:50] len (6 bits), [49:0] zero.
REQ-021 A flit transfer SHALL occur only on a clock edge with link_valid=1 and link_ready=1; HDR then moves to PAYLOAD with remaining=len.
REQ-022 In PAYLOAD, link_data SHALL equal fifo_data and link_valid SHALL equal ~fifo_empty.
REQ-023 In PAYLOAD, fifo_read_en SHALL equal link_valid & link_ready, combinationally in the same cycle as the transfer.
REQ-024 link_eof SHALL be high when remaining==1 in PAYLOAD.
REQ-025 On the eof transfer, the block SHALL return to IDLE and increment pkt_count.
REQ-026 While link_valid=1 and link_ready=0, link_data, sof and eof SHALL stay stable.
REQ-027 fifo_read_en SHALL be 0 in IDLE and HDR.
REQ-028 The block SHALL add no idle cycle between HDR and the first payload flit, or between consecutive payload flits.
REQ-029 Minimum packet time SHALL be 1 (IDLE) + 1 (HDR) + len cycles when link_ready=1.
REQ-030 fifo_empty=1 in PAYLOAD is an upstream violation: the block SHALL set underrun and hold in PAYLOAD until data arrives.
REQ-031 underrun SHALL be cleared only by reset.
REQ-032 Only this block pops the FIFO; concurrent writes SHALL NOT change the latched len.

Reset
REQ-033 Reset SHALL be asynchronous and active-high.
REQ-034 During reset, state SHALL be IDLE.
REQ-035 During reset, link_valid, link_sof, link_eof, fifo_read_en, busy and underrun SHALL be 0.
REQ-036 During reset, pkt_count and link_data SHALL be 0.
REQ-037 A reset mid-packet SHALL abandon the packet with no eof; already-popped words are lost.

Structure
REQ-038 Package noc_pkg SHALL hold the header field offsets and widths, the 64-bit flit width and the FSM state encoding.
REQ-039 The block SHALL have no sub-module; header packing is inline.

Verification
REQ-040 Scenario: 3 words in FIFO, link_ready=1 -> header len=3, 3 payload flits, eof on the 3rd, pkt_count=1.
REQ-041 Scenario: FIFO full (ocup=0, empty=0), MAX_LEN=32 -> len=32, and 32 pops occur.
REQ-042 Scenario: 20 words, MAX_LEN=8 -> packets of len 8, 8 and 4, pkt_count=3.
REQ-043 Scenario: link_ready toggling 1/0 every cycle -> no flit duplicated or dropped, and data is stable while stalled.
REQ-044 Scenario: force fifo_empty=1 mid-PAYLOAD -> underrun=1, link_valid=0, then resumes when data arrives.
REQ-045 Scenario: assert reset during the 2nd payload flit -> all outputs 0 immediately, and the next packet starts cleanly from IDLE.
